pow2_divider_seq: RTL and testbench
===================================

Name: pow2_divider_seq

Overview:
- Multi-cycle, handshaked successor to the combinational power-of-two divider in the neuron datapath.
- Computes quotient = dividend >> floor(log2(divisor)). Shift work is spread over cycles, SHIFT_STEP bits per cycle, so wide dividends close timing.
- Adds signed mode, a round-half-up option, divide-by-zero saturation and a non-power-of-two flag.
- Sits between the membrane-potential accumulator and the threshold/decay logic.

Parameters:
- DIVIDEND_WIDTH, 96, dividend and quotient width. Must be >= DIVISOR_WIDTH.
- DIVISOR_WIDTH, 32, divisor width, unsigned.
- SHIFT_STEP, 8, maximum right-shift per cycle. Power of two, 1..DIVIDEND_WIDTH.
- SIGNED, 0, 1 = dividend and quotient are two's complement with arithmetic shift; 0 = unsigned.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- dividend  in  DIVIDEND_WIDTH  numerator.
- divisor  in  DIVISOR_WIDTH  denominator, unsigned.
- round_mode  in  1  0 = truncate (floor), 1 = round half up.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- quotient  out  DIVIDEND_WIDTH  result.
- div_by_zero  out  1  divisor was 0. Valid with out_valid.
- not_pow2  out  1  divisor had more than one bit set. Valid with out_valid.

Behaviour:
- FSM states: IDLE, LOG2, SHIFT, DONE.
- Reset (any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, quotient=0, div_by_zero=0, not_pow2=0. Any in-flight request is discarded.
- in_ready=1 only in IDLE. A transfer occurs on an edge with in_valid&in_ready.
- On transfer: latch dividend, divisor and round_mode; go to LOG2.
- LOG2 (1 cycle):
  - k = index of the highest set divisor bit (priority encoder, registered).
  - not_pow2 = popcount(divisor) > 1.
  - divisor==0 -> DONE with div_by_zero=1; quotient = all ones if SIGNED=0. If SIGNED=1: quotient = max positive when dividend >= 0, else most negative.
  - k==0 -> DONE; quotient = dividend, no rounding.
  - Otherwise -> SHIFT with remaining=k and round_bit=0.
- SHIFT:
  - Each cycle, s = min(SHIFT_STEP, remaining).
  - round_bit = bit (s-1) of the working value (the last bit shifted out so far).
  - Working value >>= s (arithmetic if SIGNED). remaining -= s.
  - When remaining reaches 0 -> DONE. quotient = working value, plus round_bit if round_mode=1.
  - The round increment cannot overflow because k >= 1.
- DONE: out_valid=1. quotient and flags are held stable until out_valid&out_ready, then return to IDLE (in_ready=1 on the next cycle).
- No new request is accepted in the same cycle a result is consumed.
- Latency: out_valid rises L edges after the accepting edge.
  - L = 1 when divisor==0 or k==0.
  - Otherwise L = 1 + ceil(k/SHIFT_STEP).
  - Maximum L = 1 + ceil((DIVISOR_WIDTH-1)/SHIFT_STEP) = 5 at defaults.
- Rounding semantics: truncation is floor division (signed negatives round toward -inf). Round half up adds 2^(k-1) before the shift, so ties round toward +inf.
- out_ready high while out_valid is low has no effect. in_valid while busy is ignored and not queued.
- Input ports other than during the transfer edge are don't-care; all computation uses latched copies.

Test Plan:
- Defaults, dividend=1000, divisor=8, round_mode=0 -> quotient=125, not_pow2=0, div_by_zero=0, out_valid 2 edges after accept.
- dividend=1000, divisor=12 -> quotient=125 (k=3), not_pow2=1. dividend=1004, divisor=8, round_mode=1 -> 126; with round_mode=0 -> 125.
- dividend=2^95, divisor=2^31 -> quotient=2^64, latency 5 edges. divisor=1, dividend=0xABCD -> quotient=0xABCD, latency 1.
- divisor=0, dividend=5 -> quotient=all ones, div_by_zero=1, latency 1. SIGNED=1, divisor=0, dividend=-5 -> quotient=most negative.
- SIGNED=1, dividend=-7, divisor=2: round_mode=0 -> -4; round_mode=1 -> -3. dividend=7, divisor=2, round_mode=1 -> 4.
- Back-pressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE -> quotient and flags stable, in_ready=0, extra in_valid pulses ignored.
  - Then out_ready=1 -> in_ready=1 on the next cycle.
  - Assert Reset during SHIFT -> next cycle out_valid=0, in_ready=1, outputs 0, and no stale result later.

Source files
------------

// File: rtl/pow2_divider_seq.sv
// Sequential power-of-two divider: quotient = dividend >> floor(log2(divisor)), with the shift
// spread over cycles, optional round-half-up, divide-by-zero saturation and a non-pow2 flag.
module pow2_divider_seq #(
   parameter int unsigned DIVIDEND_WIDTH = 96,
   parameter int unsigned DIVISOR_WIDTH  = 32,
   parameter int unsigned SHIFT_STEP     = 8,
   parameter bit          SIGNED         = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   input  logic                      round_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic                      div_by_zero,
   output logic                      not_pow2
);

   localparam int unsigned DW = DIVIDEND_WIDTH;
   localparam int unsigned VW = DIVISOR_WIDTH;
   localparam int unsigned KW = (VW > 1) ? $clog2(VW) : 1;
   localparam int unsigned SW = $clog2(SHIFT_STEP + 1);
   localparam int unsigned CW = (KW > SW) ? KW : SW;
   localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);
   localparam logic [DW-1:0] MINNEG = DW'(1) << (DW - 1);
   localparam logic [DW-1:0] MAXPOS = ~MINNEG;

   typedef enum logic [1:0] {StIdle, StLog2, StShift, StDone} state_e;

   state_e          state;
   logic [DW-1:0]   work_q;
   logic [VW-1:0]   divisor_q;
   logic            round_q;
   logic [CW-1:0]   remaining_q;

   logic [CW-1:0]   k_val;
   logic            multi_bit;
   logic [CW-1:0]   step_amt;
   logic [DW-1:0]   shifted;
   logic [DW-1:0]   round_mask;
   logic            round_bit;
   logic [DW-1:0]   rounded;
   logic [DW-1:0]   sat;

   always_comb begin
      k_val = '0;
      for (int i = 0; i < int'(VW); i++) begin
         if (divisor_q[i]) k_val = CW'(i);
      end
      multi_bit = |(divisor_q & (divisor_q - VW'(1)));

      step_amt = (remaining_q > STEP) ? STEP : remaining_q;
      if (SIGNED) shifted = $signed(work_q) >>> step_amt;
      else        shifted = work_q >> step_amt;

      // Last bit shifted out in this step; only the final step's value matters for rounding.
      round_mask = DW'(1) << (step_amt - CW'(1));
      round_bit  = |(work_q & round_mask);
      rounded    = shifted + DW'(round_bit);

      if (SIGNED) sat = work_q[DW-1] ? MINNEG : MAXPOS;
      else        sat = '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         div_by_zero <= 1'b0;
         not_pow2    <= 1'b0;
         work_q      <= '0;
         divisor_q   <= '0;
         round_q     <= 1'b0;
         remaining_q <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid) begin
                  work_q    <= dividend;
                  divisor_q <= divisor;
                  round_q   <= round_mode;
                  in_ready  <= 1'b0;
                  state     <= StLog2;
               end
            end
            StLog2: begin
               not_pow2    <= multi_bit;
               div_by_zero <= (divisor_q == '0);
               if (divisor_q == '0) begin
                  quotient  <= sat;
                  out_valid <= 1'b1;
                  state     <= StDone;
               end else if (k_val == '0) begin
                  quotient  <= work_q;
                  out_valid <= 1'b1;
                  state     <= StDone;
               end else begin
                  remaining_q <= k_val;
                  state       <= StShift;
               end
            end
            StShift: begin
               work_q      <= shifted;
               remaining_q <= remaining_q - step_amt;
               if (remaining_q == step_amt) begin
                  quotient  <= round_q ? rounded : shifted;
                  out_valid <= 1'b1;
                  state     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pow2_divider_seq.sv
// Randomised and directed bench for pow2_divider_seq; an unsigned and a signed instance share
// clock and reset, and results are compared with an arithmetic reference model.
module tb_pow2_divider_seq;

   localparam logic [95:0] MINNEG = {1'b1, 95'd0};
   localparam logic [95:0] MAXPOS = {1'b0, {95{1'b1}}};

   logic        clk;
   logic        rst;
   logic [1:0]  in_valid, in_ready, round_mode, out_valid, out_ready, div_by_zero, not_pow2;
   logic [95:0] dividend [2];
   logic [95:0] quotient [2];
   logic [31:0] divisor  [2];

   int errors = 0;
   int checks = 0;

   pow2_divider_seq #(.SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .dividend(dividend[0]), .divisor(divisor[0]), .round_mode(round_mode[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .quotient(quotient[0]),
      .div_by_zero(div_by_zero[0]), .not_pow2(not_pow2[0])
   );

   pow2_divider_seq #(.SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .dividend(dividend[1]), .divisor(divisor[1]), .round_mode(round_mode[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .quotient(quotient[1]),
      .div_by_zero(div_by_zero[1]), .not_pow2(not_pow2[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference: floor((dividend + rounding offset) / 2^k) in wide signed arithmetic.
   function automatic void model(input bit sgn, input logic [95:0] dvd, input logic [31:0] dvs,
                                 input bit rm, output logic [95:0] q, output bit dz,
                                 output bit np, output int lat);
      logic signed [97:0] v;
      logic [32:0]        d1;
      int                 k;
      dz = (dvs == 32'd0);
      np = ($countones(dvs) > 1);
      if (dz) begin
         if (!sgn)        q = '1;
         else if (dvd[95]) q = MINNEG;
         else             q = MAXPOS;
         lat = 1;
         return;
      end
      d1  = {1'b0, dvs} + 33'd1;
      k   = $clog2(d1) - 1;
      lat = (k == 0) ? 1 : 1 + (k + 7) / 8;
      if (k == 0) begin
         q = dvd;
      end else begin
         v = sgn ? {{2{dvd[95]}}, dvd} : {2'b00, dvd};
         if (rm) v = v + (98'sd1 <<< (k - 1));
         v = v >>> k;
         q = v[95:0];
      end
   endfunction

   // Drives one request into the selected instance and waits for its result.
   task automatic run_op(input bit sel, input logic [95:0] dvd, input logic [31:0] dvs,
                         input bit rm, output logic [95:0] q, output bit dz, output bit np,
                         output int lat, output bit to);
      int n;
      to = 1'b0;
      @(negedge clk);
      n = 0;
      while (!in_ready[sel] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[sel]) to = 1'b1;
      in_valid[sel]   = 1'b1;
      dividend[sel]   = dvd;
      divisor[sel]    = dvs;
      round_mode[sel] = rm;
      @(posedge clk);
      #1;
      in_valid[sel]   = 1'b0;
      dividend[sel]   = {$urandom, $urandom, $urandom};
      divisor[sel]    = $urandom;
      round_mode[sel] = ~rm;
      lat = 0;
      while (!out_valid[sel] && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid[sel]) to = 1'b1;
      q  = quotient[sel];
      dz = div_by_zero[sel];
      np = not_pow2[sel];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (in_ready[i] !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]);
         end
         checks++;
         if (out_valid[i] !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]);
         end
         checks++;
         if (quotient[i] !== 96'd0) begin
            errors++; $display("FAIL reset_quotient[%0d]: got %h want 0", i, quotient[i]);
         end
         checks++;
         if (div_by_zero[i] !== 1'b0 || not_pow2[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags[%0d]: got dz=%b np=%b want 0 0", i, div_by_zero[i],
                     not_pow2[i]);
         end
      end
      rst = 1'b0;
   endtask

   typedef struct {
      bit          sgn;
      logic [95:0] dvd;
      logic [31:0] dvs;
      bit          rm;
      logic [95:0] q;
      bit          dz;
      bit          np;
      int          lat;
   } vec_t;

   task automatic test_directed();
      vec_t        v [12];
      logic [95:0] q;
      bit          dz, np, to;
      int          lat;
      v[0]  = '{1'b0, 96'd1000, 32'd8, 1'b0, 96'd125, 1'b0, 1'b0, 2};
      v[1]  = '{1'b0, 96'd1000, 32'd12, 1'b0, 96'd125, 1'b0, 1'b1, 2};
      v[2]  = '{1'b0, 96'd1004, 32'd8, 1'b1, 96'd126, 1'b0, 1'b0, 2};
      v[3]  = '{1'b0, 96'd1004, 32'd8, 1'b0, 96'd125, 1'b0, 1'b0, 2};
      v[4]  = '{1'b0, MINNEG, 32'h8000_0000, 1'b0, {31'd0, 1'b1, 64'd0}, 1'b0, 1'b0, 5};
      v[5]  = '{1'b0, 96'h0ABCD, 32'd1, 1'b0, 96'h0ABCD, 1'b0, 1'b0, 1};
      v[6]  = '{1'b0, 96'd5, 32'd0, 1'b0, {96{1'b1}}, 1'b1, 1'b0, 1};
      v[7]  = '{1'b1, 96'(-5), 32'd0, 1'b0, MINNEG, 1'b1, 1'b0, 1};
      v[8]  = '{1'b1, 96'(-7), 32'd2, 1'b0, 96'(-4), 1'b0, 1'b0, 2};
      v[9]  = '{1'b1, 96'(-7), 32'd2, 1'b1, 96'(-3), 1'b0, 1'b0, 2};
      v[10] = '{1'b1, 96'd7, 32'd2, 1'b1, 96'd4, 1'b0, 1'b0, 2};
      v[11] = '{1'b1, 96'd5, 32'd0, 1'b0, MAXPOS, 1'b1, 1'b0, 1};
      for (int i = 0; i < 12; i++) begin
         run_op(v[i].sgn, v[i].dvd, v[i].dvs, v[i].rm, q, dz, np, lat, to);
         checks++;
         if (to !== 1'b0) begin
            errors++; $display("FAIL directed[%0d] handshake: timed out", i);
         end
         checks++;
         if (q !== v[i].q) begin
            errors++; $display("FAIL directed[%0d] quotient: got %h want %h", i, q, v[i].q);
         end
         checks++;
         if (dz !== v[i].dz || np !== v[i].np) begin
            errors++;
            $display("FAIL directed[%0d] flags: got dz=%b np=%b want dz=%b np=%b", i, dz, np,
                     v[i].dz, v[i].np);
         end
         checks++;
         if (lat != v[i].lat) begin
            errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_random();
      logic [95:0] dvd, q, eq;
      logic [31:0] dvs;
      bit          sel, rm, dz, np, edz, enp, to;
      int          lat, elat;
      for (int i = 0; i < 300; i++) begin
         sel = i[0];
         rm  = 1'($urandom);
         dvd = {$urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) dvd = 96'($signed(32'($urandom_range(0, 40)) - 32'd20));
         case ($urandom_range(0, 9))
            0:       dvs = 32'd0;
            1:       dvs = 32'd1;
            2, 3, 4: dvs = 32'd1 << $urandom_range(0, 31);
            default: begin
               dvs = $urandom >> $urandom_range(0, 31);
               if (dvs == 32'd0) dvs = 32'd3;
            end
         endcase
         model(sel, dvd, dvs, rm, eq, edz, enp, elat);
         run_op(sel, dvd, dvs, rm, q, dz, np, lat, to);
         checks++;
         if (to !== 1'b0 || lat != elat) begin
            errors++;
            $display("FAIL random[%0d] latency: got %0d (timeout=%b) want %0d", i, lat, to, elat);
         end
         checks++;
         if (q !== eq) begin
            errors++;
            $display("FAIL random[%0d] quotient: s=%0d dvd=%h dvs=%h rm=%b got %h want %h", i,
                     sel, dvd, dvs, rm, q, eq);
         end
         checks++;
         if (dz !== edz) begin
            errors++; $display("FAIL random[%0d] div_by_zero: got %b want %b", i, dz, edz);
         end
         checks++;
         if (np !== enp) begin
            errors++; $display("FAIL random[%0d] not_pow2: got %b want %b", i, np, enp);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [95:0] q;
      bit          dz, np, to, seen;
      int          lat;
      out_ready[0] = 1'b0;
      run_op(1'b0, 96'd1004, 32'd12, 1'b1, q, dz, np, lat, to);
      checks++;
      if (to !== 1'b0 || q !== 96'd126 || np !== 1'b1 || dz !== 1'b0) begin
         errors++;
         $display("FAIL bp_result: got q=%h np=%b dz=%b timeout=%b want q=7e np=1 dz=0", q, np,
                  dz, to);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] handshake: got ov=%b ir=%b want 1 0", c, out_valid[0],
                     in_ready[0]);
         end
         checks++;
         if (quotient[0] !== 96'd126 || not_pow2[0] !== 1'b1 || div_by_zero[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] data: got q=%h np=%b dz=%b want 7e 1 0", c, quotient[0],
                     not_pow2[0], div_by_zero[0]);
         end
         in_valid[0] = 1'b1;
         dividend[0] = {$urandom, $urandom, $urandom};
         divisor[0]  = $urandom;
      end
      @(negedge clk);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got ov=%b ir=%b want 0 1", out_valid[0], in_ready[0]);
      end
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid[0]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL bp_no_queue: got out_valid=1 want 0");
      end
   endtask

   task automatic test_reset_midop();
      logic [95:0] q;
      bit          dz, np, to, seen;
      int          lat;
      @(negedge clk);
      in_valid[0]   = 1'b1;
      dividend[0]   = MINNEG;
      divisor[0]    = 32'h8000_0000;
      round_mode[0] = 1'b0;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL midop_reset handshake: got ov=%b ir=%b want 0 1", out_valid[0],
                  in_ready[0]);
      end
      checks++;
      if (quotient[0] !== 96'd0 || not_pow2[0] !== 1'b0 || div_by_zero[0] !== 1'b0) begin
         errors++;
         $display("FAIL midop_reset outputs: got q=%h np=%b dz=%b want 0 0 0", quotient[0],
                  not_pow2[0], div_by_zero[0]);
      end
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid[0]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL midop_stale: got out_valid=1 want 0");
      end
      run_op(1'b0, 96'd1000, 32'd8, 1'b0, q, dz, np, lat, to);
      checks++;
      if (to !== 1'b0 || q !== 96'd125 || lat != 2) begin
         errors++;
         $display("FAIL midop_recover: got q=%h lat=%0d timeout=%b want q=7d lat=2", q, lat, to);
      end
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = '0;
      out_ready  = 2'b11;
      round_mode = '0;
      for (int i = 0; i < 2; i++) begin
         dividend[i] = '0;
         divisor[i]  = '0;
      end
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
